control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 AUTO_START, default 0: when 1, the FSM SHALL leave IDLE on the first clock after reset without waiting for start.
REQ-002 clk  input  1  system clock; all state changes SHALL occur on the rising edge.
REQ-003 clr  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begins fetching from IDLE.
REQ-005 IR_Data  input  32  instruction register contents; the opcode is IR_Data[31:27].
REQ-006 CON_out  input  1  branch condition; it SHALL be ignored in this revision.
REQ-007 PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, IncPC  output  1 each  register load/increment strobes.
REQ-008 PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, C_out  output  1 each  bus drive selects.
REQ-009 Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  select-and-encode controls.
REQ-010 Read, Write  output  1 each  memory strobes.
REQ-011 alu_instruction_bits  output  5  ALU operation code.
REQ-012 run  output  1  high in every state except IDLE and HALT.
REQ-013 illegal  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-014 The FSM SHALL have the states IDLE, T0 through T7, and HALT, with exactly one step per clock cycle.
REQ-015 Outputs SHALL be a Moore decode of the state and IR_Data[31:27]; every output not listed for a step SHALL be 0.
REQ-016 IDLE SHALL go to T0 when start=1 (or AUTO_START=1); otherwise it SHALL hold.
REQ-017 Fetch: T0 = PC_out, MAR_in, IncPC, Z_in; T1 = Zlow_out, PC_in, Read, MDR_in; T2 = MDR_out, IR_in.
REQ-018 Reg-reg ALU (opcodes 00011-01011): T3 = Grb, Rout, Y_in; T4 = Grc, Rout, Z_in, alu=opcode; T5 = Zlow_out, Gra, Rin; then T0.
REQ-019 addi/andi/ori (01100/01101/01110): T3 as in REQ-018; T4 = C_out, Z_in, alu=00011/00101/00110 respectively; T5 as in REQ-018.
REQ-020 neg/not (10001/10010): T3 = Grb, Rout, Z_in, alu=opcode; T4 = Zlow_out, Gra, Rin; then T0.
REQ-021 mul/div (10000/01111): T3 = Gra, Rout, Y_in; T4 = Grb, Rout, Z_in, alu=opcode; T5 = Zlow_out, LO_in; T6 = Zhigh_out, HI_in.
REQ-022 ldi (00001): T3 = Grb, BAout, Y_in; T4 = C_out, Z_in, alu=00011; T5 = Zlow_out, Gra, Rin.
REQ-023 ld (00000): T3-T4 as ldi; T5 = Zlow_out, MAR_in; T6 = Read, MDR_in; T7 = MDR_out, Gra, Rin.
REQ-024 st (00010): T3-T5 as ld; T6 = Gra, Rout, MDR_in; T7 = Write.
REQ-025 mfhi/mflo (11000/11001): T3 = HI_out or LO_out respectively, plus Gra, Rin; then T0.
REQ-026 nop (11010): T3 SHALL drive no strobes and SHALL be followed by T0.
REQ-027 halt (11011): T3 SHALL go to HALT; HALT SHALL hold with all outputs 0 until reset.
REQ-028 Any other opcode SHALL pulse illegal in T3 and then behave as nop.
REQ-029 After the final step of each instruction the next state SHALL be T0; start SHALL be ignored outside IDLE.

Reset
REQ-030 When clr=0 the FSM SHALL enter IDLE asynchronously, and all outputs SHALL go to 0 immediately, including during an instruction.
REQ-031 After clr is released, fetch SHALL restart at T0 per REQ-016; a partially executed instruction SHALL NOT be resumed.

Configuration
REQ-032 With CU_MULDIV_EN defined, mul and div SHALL be sequenced per REQ-021; without it, they SHALL follow REQ-028.

Structure
REQ-033 Shared package cu_pkg SHALL hold the opcode constants, the ALU code constants, and the state encoding.
REQ-034 The sub-module cu_decode (combinational opcode-to-class decode) SHALL be instantiated once.

Verification
REQ-035 R3=1, IR=0x611FFFFD (addi R2,R3,-3) -> T3 Grb/Rout/Y_in; T4 C_out, alu=00011; T5 Zlow_out/Gra/Rin; R2=0xFFFFFFFE.
REQ-036 IR=0x00000000 (ld) -> Read asserted in T1 and T6, MDR_out with Rin in T7, next state T0.
REQ-037 st -> Write high only in T7, Read never high in T3-T7.
REQ-038 Opcode 11011 -> run=0 in HALT; start=1 has no effect; clr=0 then start=1 -> T0.
REQ-039 clr=0 asserted in T4 of add -> all outputs 0 within the same cycle; state IDLE.
REQ-040 Opcode 11111 -> illegal high for exactly one cycle (T3), then T0; mul without CU_MULDIV_EN -> illegal pulse.

Source files
------------

// File: rtl/cu_pkg.sv
// cu_pkg -- shared definitions for the control unit.
// Holds the opcode constants (IR_Data[31:27]), the ALU operation codes that
// the control unit places on alu_instruction_bits, the FSM state encoding and
// the instruction-class encoding produced by cu_decode.
package cu_pkg;

  // Opcodes
  localparam logic [4:0] OP_LD        = 5'b00000;
  localparam logic [4:0] OP_LDI       = 5'b00001;
  localparam logic [4:0] OP_ST        = 5'b00010;
  localparam logic [4:0] OP_ALU_FIRST = 5'b00011;
  localparam logic [4:0] OP_ALU_LAST  = 5'b01011;
  localparam logic [4:0] OP_ADDI      = 5'b01100;
  localparam logic [4:0] OP_ANDI      = 5'b01101;
  localparam logic [4:0] OP_ORI       = 5'b01110;
  localparam logic [4:0] OP_DIV       = 5'b01111;
  localparam logic [4:0] OP_MUL       = 5'b10000;
  localparam logic [4:0] OP_NEG       = 5'b10001;
  localparam logic [4:0] OP_NOT       = 5'b10010;
  localparam logic [4:0] OP_MFHI      = 5'b11000;
  localparam logic [4:0] OP_MFLO      = 5'b11001;
  localparam logic [4:0] OP_NOP       = 5'b11010;
  localparam logic [4:0] OP_HALT      = 5'b11011;

  // ALU operation codes used by the immediate and address-forming steps
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;
  localparam logic [4:0] ALU_NONE = 5'b00000;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    CL_ALU     = 4'd0,
    CL_IMM     = 4'd1,
    CL_UNARY   = 4'd2,
    CL_MULDIV  = 4'd3,
    CL_LDI     = 4'd4,
    CL_LD      = 4'd5,
    CL_ST      = 4'd6,
    CL_MFHI    = 4'd7,
    CL_MFLO    = 4'd8,
    CL_NOP     = 4'd9,
    CL_HALT    = 4'd10,
    CL_ILLEGAL = 4'd11
  } op_class_e;

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if -- bundle between the control unit and the datapath.
// Inputs to the control unit: start, IR_Data[31:0], CON_out.
// Outputs of the control unit: register strobes, bus selects, register-file
// select/encode controls, memory strobes, alu_instruction_bits[4:0], run,
// illegal.
// modport master: the control unit.  modport slave: the datapath side.
interface control_unit_if;
  logic        start;
  logic [31:0] IR_Data;
  logic        CON_out;
  logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, IncPC;
  logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, C_out;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic Read, Write;
  logic [4:0] alu_instruction_bits;
  logic run, illegal;

  modport master (
    input  start, IR_Data, CON_out,
    output PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, IncPC,
    output PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, C_out,
    output Gra, Grb, Grc, Rin, Rout, BAout, Read, Write,
    output alu_instruction_bits, run, illegal
  );

  modport slave (
    output start, IR_Data, CON_out,
    input  PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, IncPC,
    input  PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, C_out,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Read, Write,
    input  alu_instruction_bits, run, illegal
  );
endinterface

// File: rtl/cu_decode.sv
// cu_decode -- combinational opcode-to-class decode.
// Ports: opcode[4:0] in; op_class out (instruction class); alu_code[4:0] out
// (ALU operation for the compute step of that class).
// Build option: CU_MULDIV_EN -- when defined, mul/div decode to CL_MULDIV;
// otherwise they are treated as unsupported opcodes.
module cu_decode
  import cu_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_e  op_class,
  output logic [4:0] alu_code
);

  // Classify the opcode and pick the ALU operation it needs
  always_comb begin
    op_class = CL_ILLEGAL;
    alu_code = ALU_NONE;
    if ((opcode >= OP_ALU_FIRST) && (opcode <= OP_ALU_LAST)) begin
      op_class = CL_ALU;
      alu_code = opcode;
    end else begin
      case (opcode)
        OP_LD:   begin op_class = CL_LD;    alu_code = ALU_ADD; end
        OP_LDI:  begin op_class = CL_LDI;   alu_code = ALU_ADD; end
        OP_ST:   begin op_class = CL_ST;    alu_code = ALU_ADD; end
        OP_ADDI: begin op_class = CL_IMM;   alu_code = ALU_ADD; end
        OP_ANDI: begin op_class = CL_IMM;   alu_code = ALU_AND; end
        OP_ORI:  begin op_class = CL_IMM;   alu_code = ALU_OR;  end
        OP_NEG, OP_NOT: begin op_class = CL_UNARY; alu_code = opcode; end
`ifdef CU_MULDIV_EN
        OP_MUL, OP_DIV: begin op_class = CL_MULDIV; alu_code = opcode; end
`endif
        OP_MFHI: op_class = CL_MFHI;
        OP_MFLO: op_class = CL_MFLO;
        OP_NOP:  op_class = CL_NOP;
        OP_HALT: op_class = CL_HALT;
        default: op_class = CL_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// control_unit -- microsequencer for the CPU datapath.
// Ports: clk (rising edge), clr (asynchronous, active-low reset),
//        bus (control_unit_if.master: start, IR_Data, CON_out in; all
//        strobes/selects, alu_instruction_bits, run, illegal out).
// Parameter AUTO_START: when 1, IDLE is left on the first clock after reset.
// Build option: CU_MULDIV_EN enables the mul/div sequence (see cu_decode).
// Outputs are a Moore decode of the state register and the current opcode, so
// they fall to 0 as soon as clr forces the state to IDLE. CON_out is unused in
// this revision.
module control_unit
  import cu_pkg::*;
#(
  parameter bit AUTO_START = 1'b0
)(
  input  logic clk,
  input  logic clr,
  control_unit_if.master bus
);

  state_e     state_q, state_d;
  op_class_e  op_class_s;
  logic [4:0] alu_code_s;
  logic [27:0] ir_unused;

  assign ir_unused = {bus.CON_out, bus.IR_Data[26:0]};

  cu_decode u_decode (
    .opcode  (bus.IR_Data[31:27]),
    .op_class(op_class_s),
    .alu_code(alu_code_s)
  );

  // State register with asynchronous clear to IDLE
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state sequencing; each class ends by returning to T0
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start || AUTO_START) state_d = S_T0;
        else                         state_d = S_IDLE;
      end
      S_T0: state_d = S_T1;
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: begin
        case (op_class_s)
          CL_ALU, CL_IMM, CL_UNARY, CL_MULDIV,
          CL_LDI, CL_LD, CL_ST: state_d = S_T4;
          CL_HALT:              state_d = S_HALT;
          default:              state_d = S_T0;
        endcase
      end
      S_T4: begin
        case (op_class_s)
          CL_ALU, CL_IMM, CL_MULDIV, CL_LDI, CL_LD, CL_ST: state_d = S_T5;
          default: state_d = S_T0;
        endcase
      end
      S_T5: begin
        case (op_class_s)
          CL_MULDIV, CL_LD, CL_ST: state_d = S_T6;
          default:                 state_d = S_T0;
        endcase
      end
      S_T6: begin
        case (op_class_s)
          CL_LD, CL_ST: state_d = S_T7;
          default:      state_d = S_T0;
        endcase
      end
      S_T7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode of state and instruction class
  always_comb begin
    bus.PC_in = 1'b0;  bus.IR_in = 1'b0;  bus.Y_in = 1'b0;   bus.Z_in = 1'b0;
    bus.HI_in = 1'b0;  bus.LO_in = 1'b0;  bus.MAR_in = 1'b0; bus.MDR_in = 1'b0;
    bus.IncPC = 1'b0;  bus.PC_out = 1'b0; bus.Zhigh_out = 1'b0;
    bus.Zlow_out = 1'b0; bus.HI_out = 1'b0; bus.LO_out = 1'b0;
    bus.MDR_out = 1'b0; bus.C_out = 1'b0; bus.Gra = 1'b0; bus.Grb = 1'b0;
    bus.Grc = 1'b0;    bus.Rin = 1'b0;   bus.Rout = 1'b0;   bus.BAout = 1'b0;
    bus.Read = 1'b0;   bus.Write = 1'b0; bus.alu_instruction_bits = ALU_NONE;
    bus.illegal = 1'b0;
    bus.run = (state_q != S_IDLE) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin bus.PC_out = 1'b1; bus.MAR_in = 1'b1; bus.IncPC = 1'b1; bus.Z_in = 1'b1; end
      S_T1: begin bus.Zlow_out = 1'b1; bus.PC_in = 1'b1; bus.Read = 1'b1; bus.MDR_in = 1'b1; end
      S_T2: begin bus.MDR_out = 1'b1; bus.IR_in = 1'b1; end
      S_T3: begin
        case (op_class_s)
          CL_ALU, CL_IMM: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Y_in = 1'b1; end
          CL_UNARY: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Z_in = 1'b1;
            bus.alu_instruction_bits = alu_code_s;
          end
          CL_MULDIV: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Y_in = 1'b1; end
          CL_LDI, CL_LD, CL_ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Y_in = 1'b1; end
          CL_MFHI: begin bus.HI_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CL_MFLO: begin bus.LO_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CL_ILLEGAL: bus.illegal = 1'b1;
          default: ;  // nop and halt drive no strobes
        endcase
      end
      S_T4: begin
        case (op_class_s)
          CL_ALU: begin
            bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Z_in = 1'b1;
            bus.alu_instruction_bits = alu_code_s;
          end
          CL_IMM, CL_LDI, CL_LD, CL_ST: begin
            bus.C_out = 1'b1; bus.Z_in = 1'b1;
            bus.alu_instruction_bits = alu_code_s;
          end
          CL_UNARY: begin bus.Zlow_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CL_MULDIV: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Z_in = 1'b1;
            bus.alu_instruction_bits = alu_code_s;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (op_class_s)
          CL_ALU, CL_IMM, CL_LDI: begin bus.Zlow_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CL_MULDIV: begin bus.Zlow_out = 1'b1; bus.LO_in = 1'b1; end
          CL_LD, CL_ST: begin bus.Zlow_out = 1'b1; bus.MAR_in = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (op_class_s)
          CL_MULDIV: begin bus.Zhigh_out = 1'b1; bus.HI_in = 1'b1; end
          CL_LD: begin bus.Read = 1'b1; bus.MDR_in = 1'b1; end
          CL_ST: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDR_in = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        case (op_class_s)
          CL_LD: begin bus.MDR_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CL_ST: bus.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;  // IDLE and HALT drive nothing
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic clk;
  logic clr;

  control_unit_if cu_bus();
  control_unit_if auto_bus();

  control_unit #(.AUTO_START(1'b0)) dut (.clk(clk), .clr(clr), .bus(cu_bus));
  control_unit #(.AUTO_START(1'b1)) dut_auto (.clk(clk), .clr(clr), .bus(auto_bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit layout of the packed observation vector
  localparam logic [30:0] M_PC_IN   = 31'd1 << 0;
  localparam logic [30:0] M_IR_IN   = 31'd1 << 1;
  localparam logic [30:0] M_Y_IN    = 31'd1 << 2;
  localparam logic [30:0] M_Z_IN    = 31'd1 << 3;
  localparam logic [30:0] M_HI_IN   = 31'd1 << 4;
  localparam logic [30:0] M_LO_IN   = 31'd1 << 5;
  localparam logic [30:0] M_MAR_IN  = 31'd1 << 6;
  localparam logic [30:0] M_MDR_IN  = 31'd1 << 7;
  localparam logic [30:0] M_INC_PC  = 31'd1 << 8;
  localparam logic [30:0] M_PC_OUT  = 31'd1 << 9;
  localparam logic [30:0] M_ZHIGH   = 31'd1 << 10;
  localparam logic [30:0] M_ZLOW    = 31'd1 << 11;
  localparam logic [30:0] M_HI_OUT  = 31'd1 << 12;
  localparam logic [30:0] M_LO_OUT  = 31'd1 << 13;
  localparam logic [30:0] M_MDR_OUT = 31'd1 << 14;
  localparam logic [30:0] M_C_OUT   = 31'd1 << 15;
  localparam logic [30:0] M_GRA     = 31'd1 << 16;
  localparam logic [30:0] M_GRB     = 31'd1 << 17;
  localparam logic [30:0] M_GRC     = 31'd1 << 18;
  localparam logic [30:0] M_RIN     = 31'd1 << 19;
  localparam logic [30:0] M_ROUT    = 31'd1 << 20;
  localparam logic [30:0] M_BAOUT   = 31'd1 << 21;
  localparam logic [30:0] M_READ    = 31'd1 << 22;
  localparam logic [30:0] M_WRITE   = 31'd1 << 23;
  localparam logic [30:0] M_RUN     = 31'd1 << 24;
  localparam logic [30:0] M_ILLEGAL = 31'd1 << 25;

  localparam logic [30:0] F0 = M_RUN | M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN;
  localparam logic [30:0] F1 = M_RUN | M_ZLOW | M_PC_IN | M_READ | M_MDR_IN;
  localparam logic [30:0] F2 = M_RUN | M_MDR_OUT | M_IR_IN;
  localparam logic [30:0] WB = M_RUN | M_ZLOW | M_GRA | M_RIN;

`ifdef CU_MULDIV_EN
  localparam bit MULDIV_ON = 1'b1;
`else
  localparam bit MULDIV_ON = 1'b0;
`endif

  function automatic logic [30:0] alu(input logic [4:0] c);
    alu = {c, 26'd0};
  endfunction

  logic [30:0] obs;
  assign obs = {cu_bus.alu_instruction_bits, cu_bus.illegal, cu_bus.run,
                cu_bus.Write, cu_bus.Read, cu_bus.BAout, cu_bus.Rout, cu_bus.Rin,
                cu_bus.Grc, cu_bus.Grb, cu_bus.Gra, cu_bus.C_out, cu_bus.MDR_out,
                cu_bus.LO_out, cu_bus.HI_out, cu_bus.Zlow_out, cu_bus.Zhigh_out,
                cu_bus.PC_out, cu_bus.IncPC, cu_bus.MDR_in, cu_bus.MAR_in,
                cu_bus.LO_in, cu_bus.HI_in, cu_bus.Z_in, cu_bus.Y_in,
                cu_bus.IR_in, cu_bus.PC_in};

  int total = 0;
  int bad   = 0;

  logic [30:0] exp_seq [0:7];
  int          exp_len;
  bit          exp_halt;

  typedef struct {
    logic [31:0]        ir;
    int                 len;
    logic [7:0][30:0]   st;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input logic [30:0] act, input logic [30:0] exp, input string name);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: micro-program of one instruction, listed step by step
  task automatic build_model(input logic [4:0] op);
    int o;
    o = int'(op);
    exp_seq[0] = F0; exp_seq[1] = F1; exp_seq[2] = F2;
    for (int k = 3; k < 8; k++) exp_seq[k] = '0;
    exp_len = 4;
    exp_halt = 1'b0;
    if (o >= 3 && o <= 11) begin
      exp_seq[3] = M_RUN | M_GRB | M_ROUT | M_Y_IN;
      exp_seq[4] = M_RUN | M_GRC | M_ROUT | M_Z_IN | alu(op);
      exp_seq[5] = WB;
      exp_len = 6;
    end else if (o >= 12 && o <= 14) begin
      exp_seq[3] = M_RUN | M_GRB | M_ROUT | M_Y_IN;
      exp_seq[4] = M_RUN | M_C_OUT | M_Z_IN |
                   alu((o == 12) ? 5'd3 : ((o == 13) ? 5'd5 : 5'd6));
      exp_seq[5] = WB;
      exp_len = 6;
    end else if (o == 17 || o == 18) begin
      exp_seq[3] = M_RUN | M_GRB | M_ROUT | M_Z_IN | alu(op);
      exp_seq[4] = WB;
      exp_len = 5;
    end else if ((o == 15 || o == 16) && MULDIV_ON) begin
      exp_seq[3] = M_RUN | M_GRA | M_ROUT | M_Y_IN;
      exp_seq[4] = M_RUN | M_GRB | M_ROUT | M_Z_IN | alu(op);
      exp_seq[5] = M_RUN | M_ZLOW | M_LO_IN;
      exp_seq[6] = M_RUN | M_ZHIGH | M_HI_IN;
      exp_len = 7;
    end else if (o <= 2) begin
      exp_seq[3] = M_RUN | M_GRB | M_BAOUT | M_Y_IN;
      exp_seq[4] = M_RUN | M_C_OUT | M_Z_IN | alu(5'd3);
      if (o == 1) begin
        exp_seq[5] = WB;
        exp_len = 6;
      end else begin
        exp_seq[5] = M_RUN | M_ZLOW | M_MAR_IN;
        exp_seq[6] = (o == 0) ? (M_RUN | M_READ | M_MDR_IN) : (M_RUN | M_GRA | M_ROUT | M_MDR_IN);
        exp_seq[7] = (o == 0) ? (M_RUN | M_MDR_OUT | M_GRA | M_RIN) : (M_RUN | M_WRITE);
        exp_len = 8;
      end
    end else if (o == 24) begin
      exp_seq[3] = M_RUN | M_HI_OUT | M_GRA | M_RIN;
    end else if (o == 25) begin
      exp_seq[3] = M_RUN | M_LO_OUT | M_GRA | M_RIN;
    end else if (o == 26) begin
      exp_seq[3] = M_RUN;
    end else if (o == 27) begin
      exp_seq[3] = M_RUN;
      exp_halt = 1'b1;
    end else begin
      exp_seq[3] = M_RUN | M_ILLEGAL;
    end
  endtask

  // Step the DUT through exp_seq[first..last]; start toggles randomly (ignored)
  task automatic run_seq(input logic [31:0] ir, input int first, input int last, input string tag);
    for (int k = first; k <= last; k++) begin
      @(negedge clk);
      cu_bus.IR_Data = ir;
      cu_bus.start = 1'($urandom_range(0, 1));
      #1;
      check(obs, exp_seq[k], $sformatf("%s_T%0d", tag, k));
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ir, input int len,
                              input logic [30:0] t3, input logic [30:0] t4,
                              input logic [30:0] t5, input logic [30:0] t6,
                              input logic [30:0] t7);
    vec_t v;
    v.ir = ir; v.len = len;
    v.st[0] = F0; v.st[1] = F1; v.st[2] = F2;
    v.st[3] = t3; v.st[4] = t4; v.st[5] = t5; v.st[6] = t6; v.st[7] = t7;
    return v;
  endfunction

  initial begin
    logic [31:0] ir;
    logic [4:0]  op;

    // Directed vectors written out by hand
    tbl.push_back(mk(32'h611FFFFD, 6, M_RUN | M_GRB | M_ROUT | M_Y_IN,
                     M_RUN | M_C_OUT | M_Z_IN | alu(5'b00011), WB, 31'd0, 31'd0));
    tbl.push_back(mk(32'h00000000, 8, M_RUN | M_GRB | M_BAOUT | M_Y_IN,
                     M_RUN | M_C_OUT | M_Z_IN | alu(5'b00011), M_RUN | M_ZLOW | M_MAR_IN,
                     M_RUN | M_READ | M_MDR_IN, M_RUN | M_MDR_OUT | M_GRA | M_RIN));
    tbl.push_back(mk(32'h10000000, 8, M_RUN | M_GRB | M_BAOUT | M_Y_IN,
                     M_RUN | M_C_OUT | M_Z_IN | alu(5'b00011), M_RUN | M_ZLOW | M_MAR_IN,
                     M_RUN | M_GRA | M_ROUT | M_MDR_IN, M_RUN | M_WRITE));
    tbl.push_back(mk(32'hC8000000, 4, M_RUN | M_LO_OUT | M_GRA | M_RIN, 31'd0, 31'd0, 31'd0, 31'd0));
    tbl.push_back(mk(32'hF8000000, 4, M_RUN | M_ILLEGAL, 31'd0, 31'd0, 31'd0, 31'd0));
    tbl.push_back(mk(32'h88000000, 5, M_RUN | M_GRB | M_ROUT | M_Z_IN | alu(5'b10001),
                     WB, 31'd0, 31'd0, 31'd0));
    tbl.push_back(mk(32'hD0000000, 4, M_RUN, 31'd0, 31'd0, 31'd0, 31'd0));
`ifdef CU_MULDIV_EN
    tbl.push_back(mk(32'h80000000, 7, M_RUN | M_GRA | M_ROUT | M_Y_IN,
                     M_RUN | M_GRB | M_ROUT | M_Z_IN | alu(5'b10000),
                     M_RUN | M_ZLOW | M_LO_IN, M_RUN | M_ZHIGH | M_HI_IN, 31'd0));
`else
    tbl.push_back(mk(32'h80000000, 4, M_RUN | M_ILLEGAL, 31'd0, 31'd0, 31'd0, 31'd0));
`endif

    cu_bus.start = 1'b0; cu_bus.IR_Data = 32'd0; cu_bus.CON_out = 1'b0;
    auto_bus.start = 1'b0; auto_bus.IR_Data = 32'd0; auto_bus.CON_out = 1'b0;
    clr = 1'b1;
    #1 clr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check(obs, 31'd0, "reset_zero");
    check(31'({auto_bus.run, auto_bus.PC_out}), 31'd0, "auto_reset_zero");

    // Release reset; main DUT waits for start, auto DUT fetches at once
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    #1;
    check(obs, 31'd0, "idle_hold_1");
    check(31'({auto_bus.run, auto_bus.PC_out, auto_bus.MAR_in, auto_bus.IncPC, auto_bus.Z_in}),
          31'd31, "auto_start_T0");
    @(negedge clk);
    #1;
    check(obs, 31'd0, "idle_hold_2");

    @(negedge clk);
    cu_bus.start = 1'b1;

    // Table-driven directed instructions
    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < 8; k++) exp_seq[k] = tbl[i].st[k];
      exp_len = tbl[i].len;
      run_seq(tbl[i].ir, 0, exp_len - 1, $sformatf("tbl%0d", i));
    end

    // Randomized instructions against the reference model
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      ir = {op, 27'($urandom)};
      build_model(op);
      run_seq(ir, 0, exp_len - 1, $sformatf("rand%0d_op%0d", i, op));
    end

    // Halt: outputs stay 0 and start has no effect
    build_model(5'd27);
    run_seq(32'hD8000000, 0, exp_len - 1, "halt");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cu_bus.start = 1'b1;
      #1;
      check(obs, 31'd0, $sformatf("halt_hold_%0d", i));
    end
    @(negedge clk);
    cu_bus.IR_Data = 32'h18000000;
    clr = 1'b0;
    #1;
    check(obs, 31'd0, "clr_in_halt");
    @(negedge clk);
    clr = 1'b1;
    cu_bus.start = 1'b1;

    // Restarted fetch of an add, cleared in T4
    build_model(5'd3);
    run_seq(32'h18000000, 0, 4, "add_after_halt");
    #1;
    clr = 1'b0;
    #1;
    check(obs, 31'd0, "clr_mid_T4");
    @(negedge clk);
    clr = 1'b1;
    cu_bus.start = 1'b0;
    #1;
    check(obs, 31'd0, "no_resume_1");
    @(negedge clk);
    #1;
    check(obs, 31'd0, "no_resume_2");
    @(negedge clk);
    cu_bus.start = 1'b1;
    @(negedge clk);
    cu_bus.start = 1'b0;
    #1;
    check(obs, F0, "fetch_after_clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
